// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW over a word-indexed data memory.
// Optional `MISALIGN_TRAP_EN: misaligned H/W accesses raise resp_err instead of being aligned down.
module load_store_unit #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  localparam logic [31:0] DEPTH_W = MEM_DEPTH;

  state_t      state, state_next;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        funct3_ok;
  logic        out_of_range;
  logic        req_err;
  logic [1:0]  req_lane;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Request decode; lane is aligned down so the non-trapping build can proceed on misaligned H/W.
  always_comb begin
    funct3_ok    = 1'b0;
    out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_W);
    req_lane     = req_addr[1:0];
    if (req_store)
      funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      funct3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    if (req_funct3[1:0] == 2'b01)
      req_lane = {req_addr[1], 1'b0};
    else if (req_funct3[1:0] == 2'b10)
      req_lane = 2'b00;
`ifdef MISALIGN_TRAP_EN
    req_err = !funct3_ok || out_of_range ||
              ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_err = !funct3_ok || out_of_range;
`endif
  end

  // Lane extraction for loads and lane merge for read-modify-write stores.
  always_comb begin
    byte_v   = mem_read_data[8*lane_q +: 8];
    half_v   = lane_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_ext = mem_read_data;
    merged   = mem_read_data;
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_ext = {24'h0, byte_v};
      3'b001:  load_ext = {{16{half_v[15]}}, half_v};
      3'b101:  load_ext = {16'h0, half_v};
      default: load_ext = mem_read_data;
    endcase
    if (funct3_q[1:0] == 2'b00)
      merged[8*lane_q +: 8] = wdata_q[7:0];
    else if (lane_q[1])
      merged[31:16] = wdata_q;
    else
      merged[15:0] = wdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                    state_next = RESP;
          else if (!req_store)            state_next = LOAD;
          else if (req_funct3 == 3'b010)  state_next = WRITE;
          else                            state_next = RMW_RD;
        end
      end
      LOAD: begin
        mem_read_enable = 1'b1;
        state_next      = RESP;
      end
      RMW_RD: begin
        mem_read_enable = 1'b1;
        state_next      = WRITE;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        state_next       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields and memory address are latched once at acceptance and held until the response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      funct3_q       <= 3'b000;
      lane_q         <= 2'b00;
      wdata_q        <= 16'h0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
      resp_rdata     <= 32'h0;
      resp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q    <= req_funct3;
            lane_q      <= req_lane;
            wdata_q     <= req_wdata[15:0];
            mem_address <= {2'b00, req_addr[31:2]};
            resp_rdata  <= 32'h0;
            resp_err    <= req_err;
            if (req_store && (req_funct3 == 3'b010) && !req_err)
              mem_write_data <= req_wdata;
          end
        end
        LOAD:    resp_rdata     <= load_ext;
        RMW_RD:  mem_write_data <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the execute stage and data_memory. Converts RV32I load/store requests (byte addresses, LB/LH/LW/LBU/LHU/SB/SH/SW) into word-indexed accesses on the data memory port.
- Loads: extracts the byte/half lane and sign- or zero-extends it.
- Sub-word stores: data memory has no byte enables, so they run as read-modify-write.
- Responds to the pipeline through a valid/ready handshake.

Parameters:
MEM_DEPTH, 1024, number of 32-bit words in data memory; word index >= MEM_DEPTH is out of range.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept request (high only in IDLE)
req_store  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  response available
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  load result after extension (0 for stores)
resp_err  output  1  misaligned, out-of-range or illegal funct3
mem_read_enable  output  1  to data_memory
mem_write_enable  output  1  to data_memory
mem_address  output  32  word index = addr[31:2], zero-extended
mem_write_data  output  32  word to write
mem_read_data  input  32  combinational read data from data_memory

Behaviour:
- Reset values: state IDLE; resp_valid=0, resp_rdata=0, resp_err=0; mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_write_data=0; req_ready=1 after reset.
- Reset mid-operation: abort immediately, return to IDLE. No write may be issued after reset deasserts.
- Request latch: on req_valid & req_ready in IDLE, latch store, funct3, addr and wdata. req_ready drops the next cycle.
- Error check at acceptance (err sets; state goes to RESP at T+1; no memory enable ever asserted):
  - funct3 not in the legal set for the op (stores: only 000/001/010);
  - H/HU with addr[0]=1, or W with addr[1:0]!=0;
  - addr[31:2] >= MEM_DEPTH.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
  - IDLE: to LOAD for a load, to RMW_RD for SB/SH, to WRITE for SW.
  - LOAD: mem_read_enable=1. Capture lane addr[1:0] from mem_read_data, sign-extend (B/H) or zero-extend (BU/HU) into resp_rdata. Next state RESP.
  - RMW_RD: mem_read_enable=1. Merge the store lane into mem_read_data and register the result as mem_write_data. Next state WRITE.
  - WRITE: mem_write_enable=1 for exactly one cycle; memory captures at the closing edge. Next state RESP.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready. On resp_ready, go to IDLE.
- Enables: mem_read_enable and mem_write_enable are decoded from the state register only. They are never both high. mem_address is held constant from LOAD/RMW_RD through WRITE.
- Lane select: byte lane = addr[1:0] (little-endian, byte 0 = bits 7:0); half lane = addr[1].
- Latency with resp_ready=1:
  - LW/LB/LH: resp_valid at T+2.
  - SW: resp_valid at T+2.
  - SB/SH: resp_valid at T+3.
  - Error: resp_valid at T+1.
- Throughput: one outstanding request. Back-to-back acceptance is possible the cycle after the RESP handshake.
- Store responses: resp_rdata=0.

Optional Feature:
MISALIGN_TRAP_EN.
- Defined: misaligned H/W accesses raise resp_err with no memory access, as above.
- Undefined: misaligned accesses are silently aligned down (H clears addr[0], W clears addr[1:0]) and proceed normally with resp_err=0. Out-of-range and illegal-funct3 errors remain active in both builds.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF; then LW 0x10 -> one write to word 4; LW resp_rdata=0xDEADBEEF at T+2, err=0.
- Word 4 = 0xDEADBEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- Word 4 = 0xDEADBEEF; SB 0x11, wdata 0x55 -> exactly one RMW read then one write of 0xDEAD55EF; resp at T+3. SH 0x12, wdata 0x1234 -> 0x123455EF.
- LW 0x12 (MISALIGN_TRAP_EN defined) -> resp_err=1 at T+1, no enable asserted. Without the macro -> reads word 4, err=0.
- LW 0x1000 with MEM_DEPTH=1024 -> resp_err=1, no access. SB with funct3=100 -> resp_err=1.
- Hold resp_ready=0 for 5 cycles: resp_valid/resp_rdata stable, req_ready=0. Assert reset during WRITE of an SB -> outputs return to reset values, no further write issued.
